// File: rtl/gpio_serial_loader.sv
// ---------------------------------------------------------------------------
// gpio_serial_loader
//
// Purpose:
//   Management-side transmitter for the GPIO pad-configuration shift chain.
//   A start request snapshots one PAD_CTRL_BITS-wide word per GPIO. The words
//   are shifted serially down the chain of gpio_control_block stages, and then
//   serial_load is pulsed so that every stage latches its word at once.
//
//   Transmission order: GPIO NUM_GPIO-1 goes first and GPIO 0 goes last. Each
//   word is sent MSB first. That order is exactly cfg_words read from bit
//   NBITS-1 down to bit 0, so the snapshot is simply rotated left once per bit.
//   After NBITS rotations the snapshot is back in its original form.
//
// Optional feature (macro GPIO_SERIAL_READBACK_EN):
//   This adds the serial_data_return input from the chain tail and the
//   readback_err / readback_valid outputs. The bits that fall out of the chain
//   tail are compared against a copy of the previous transfer's snapshot.
//
// Ports:
//   clk              system clock
//   resetn           asynchronous active-low reset
//   start            one-cycle transfer request (ignored unless idle)
//   cfg_words        NUM_GPIO packed config words, GPIO i at [i*PAD_CTRL_BITS +: PAD_CTRL_BITS]
//   busy             transfer in progress
//   done             one-cycle completion pulse
//   serial_clock     chain shift clock
//   serial_data_out  chain data, stable around every serial_clock rising edge
//   serial_load      chain latch strobe, active high
//   serial_data_return, readback_err, readback_valid  (readback build only)
// ---------------------------------------------------------------------------
module gpio_serial_loader #(
  parameter int NUM_GPIO      = 19,
  parameter int PAD_CTRL_BITS = 13,
  parameter int CLK_DIV       = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
  input  logic [NUM_GPIO*PAD_CTRL_BITS-1:0] cfg_words,
  output logic                              busy,
  output logic                              done,
  output logic                              serial_clock,
  output logic                              serial_data_out,
  output logic                              serial_load
`ifdef GPIO_SERIAL_READBACK_EN
  ,
  input  logic                              serial_data_return,
  output logic                              readback_err,
  output logic                              readback_valid
`endif
);

  localparam int NBITS = NUM_GPIO * PAD_CTRL_BITS;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t             state_reg;
  logic [NBITS-1:0]   snap_reg;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               sclk_reg;
  logic               sdata_reg;
  logic               load_reg;

  logic [NBITS-1:0]   snap_rot;
  logic               div_wrap;

  // Next bit to send always sits in the MSB of the rotated snapshot.
  assign snap_rot = {snap_reg[NBITS-2:0], snap_reg[NBITS-1]};
  assign div_wrap = (div_cnt_reg == DIV_LAST);

`ifdef GPIO_SERIAL_READBACK_EN
  // Copy of what the chain should hold from the previous transfer. It is
  // rotated in lock-step with snap_reg so that its MSB is the bit that is
  // expected at the chain tail on the current rising edge.
  logic [NBITS-1:0]   prev_reg;
  logic [NBITS-1:0]   prev_rot;
  logic               rb_sticky_reg;
  logic               rb_err_reg;
  logic               rb_valid_reg;

  assign prev_rot       = {prev_reg[NBITS-2:0], prev_reg[NBITS-1]};
  assign readback_err   = rb_err_reg;
  assign readback_valid = rb_valid_reg;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      snap_reg      <= '0;
      bit_cnt_reg   <= '0;
      div_cnt_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sclk_reg      <= 1'b0;
      sdata_reg     <= 1'b0;
      load_reg      <= 1'b0;
`ifdef GPIO_SERIAL_READBACK_EN
      // The chain reset clears every stage, so the expected contents are zero.
      prev_reg      <= '0;
      rb_sticky_reg <= 1'b0;
      rb_err_reg    <= 1'b0;
      rb_valid_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          sclk_reg    <= 1'b0;
          load_reg    <= 1'b0;
          div_cnt_reg <= '0;
          bit_cnt_reg <= '0;
          if (start) begin
            snap_reg  <= cfg_words;
            sdata_reg <= cfg_words[NBITS-1];
            busy_reg  <= 1'b1;
            state_reg <= ST_SHIFT;
`ifdef GPIO_SERIAL_READBACK_EN
            rb_sticky_reg <= 1'b0;
            rb_valid_reg  <= 1'b0;
`endif
          end
        end

        ST_SHIFT: begin
          if (div_wrap) begin
            div_cnt_reg <= '0;
            if (!sclk_reg) begin
              // Low phase over: raise serial_clock. The chain has not shifted
              // yet, so the tail still shows the bit that is about to fall out.
              sclk_reg <= 1'b1;
`ifdef GPIO_SERIAL_READBACK_EN
              if (serial_data_return != prev_reg[NBITS-1]) begin
                rb_sticky_reg <= 1'b1;
              end
`endif
            end else begin
              // High phase over: falling edge. This is the only place where the
              // data line may move, which keeps it stable around the rising edge.
              sclk_reg    <= 1'b0;
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
              snap_reg    <= snap_rot;
`ifdef GPIO_SERIAL_READBACK_EN
              prev_reg    <= prev_rot;
`endif
              if (bit_cnt_reg == BIT_LAST) begin
                // The last bit stays on the line through LOAD.
                state_reg <= ST_LOAD;
                load_reg  <= 1'b1;
              end else begin
                sdata_reg <= snap_rot[NBITS-1];
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end

        ST_LOAD: begin
          // The strobe is high for CLK_DIV cycles, then low for CLK_DIV cycles.
          if (div_wrap) begin
            div_cnt_reg <= '0;
            if (load_reg) begin
              load_reg <= 1'b0;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
`ifdef GPIO_SERIAL_READBACK_EN
              rb_err_reg   <= rb_sticky_reg;
              rb_valid_reg <= 1'b1;
              prev_reg     <= snap_reg;
`endif
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end

        ST_DONE: begin
          // A start in this cycle is deliberately dropped.
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign serial_clock    = sclk_reg;
  assign serial_data_out = sdata_reg;
  assign serial_load     = load_reg;

endmodule
